vga_sync_decoder: RTL

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 81 ++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: VGA sync timing recovery with active-window decode and lock FSM; define VGA_SYNC_DECODER_ERRCNT_EN to enable err_cnt
module vga_sync_decoder #(
  parameter int H_ACT_START = 143,
  parameter int H_ACT = 640,
  parameter int V_ACT_START = 34,
  parameter int V_ACT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] col,
  output logic [8:0] row,
  output logic       de,
  output logic [9:0] h_total,
  output logic [9:0] v_total,
  output logic       frame_start,
  output logic       locked,
  output logic [7:0] err_cnt
);
  localparam logic [9:0] HS = 10'(H_ACT_START);
  localparam logic [9:0] HE = 10'(H_ACT_START + H_ACT);
  localparam logic [9:0] VS = 10'(V_ACT_START);
  localparam logic [9:0] VE = 10'(V_ACT_START + V_ACT);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  state_t state, state_nx;
  logic [9:0] hcnt, vcnt;
  logic hs_prev, vs_prev, vs_pend, mismatch;
  logic hs_edge, vs_edge, restart, line_mm, sat, v_same;
  always_comb begin
    hs_edge = pix_en & hs_prev & ~hsync_in;
    vs_edge = pix_en & vs_prev & ~vsync_in;
    restart = hs_edge & (vs_pend | vs_edge);
    line_mm = hs_edge & (hcnt + 10'd1 != h_total);
    sat = (&hcnt) | (&vcnt);
    v_same = vcnt + 10'd1 == v_total;
    state_nx = sat ? SEARCH
      : state == SEARCH ? (restart ? ACQUIRE : SEARCH)
      : state == ACQUIRE ? (restart && v_same && !mismatch && !line_mm ? LOCKED : ACQUIRE)
      : (line_mm || (restart && !v_same)) ? SEARCH : LOCKED;
    de = hcnt >= HS && hcnt < HE && vcnt >= VS && vcnt < VE;
    col = de ? hcnt - HS : '0;
    row = de ? 9'(vcnt - VS) : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
      h_total <= '0;
      v_total <= '0;
      vs_pend <= 1'b0;
      mismatch <= 1'b0;
      frame_start <= 1'b0;
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
      state <= SEARCH;
      locked <= 1'b0;
    end else begin
      hs_prev <= pix_en ? hsync_in : hs_prev;
      vs_prev <= pix_en ? vsync_in : vs_prev;
      frame_start <= restart;
      state <= state_nx;
      locked <= state_nx == LOCKED;
      vs_pend <= restart ? 1'b0 : vs_pend | vs_edge;
      mismatch <= restart ? 1'b0 : mismatch | line_mm;
      if (restart) v_total <= vcnt + 10'd1;
      if (hs_edge) begin
        h_total <= hcnt + 10'd1;
        hcnt <= '0;
        vcnt <= restart ? '0 : (&vcnt) ? vcnt : vcnt + 10'd1;
      end else if (pix_en) hcnt <= (&hcnt) ? hcnt : hcnt + 10'd1;
    end
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  always_ff @(posedge clk)
    if (rst) err_cnt <= '0;
    else if (state == LOCKED && state_nx == SEARCH && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
`else
  assign err_cnt = '0;
`endif
endmodule
